ppc_mem_read_arbiter: RTL and testbench

//  Shares one pipelined memory read port between two requesters: instruction fetch (F) and load unit (L).
//  It arbitrates, issues registered requests to memory and tracks in-flight reads in a tag pipeline.

---
 rtl/ppc_mem_read_arbiter.sv | 150 +++++++++++++++
 tb/tb_ppc_mem_read_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppc_mem_read_arbiter.sv
// ---------------------------------------------------------------------------
// ppc_mem_read_arbiter
//
// Shares one pipelined memory read port between instruction fetch (F) and
// the load unit (L). A combinational arbiter grants one requester per cycle.
// The grant is registered onto the memory request (mem_en/mem_addr). A tag
// pipeline of LAT+1 {valid, owner} stages tracks every in-flight read, so
// each returning doubleword is steered back to the side that issued it.
// Total latency from gnt to rvalid is LAT+1 cycles.
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   -> round-robin. On contention the side not granted last wins.
//   undefined -> fixed priority, L over F. F may wait while l_req stays high.
//
// Bit numbering: the big-endian [0:60] / [0:63] fields map onto [AW-1:0] /
// [DW-1:0] here. Big-endian bit 0 is the MSB.
//
// Ports
//   clk                  rising-edge clock
//   reset                synchronous, active-high reset
//   f_req / f_addr       fetch request and doubleword address, held until f_gnt
//   f_gnt                fetch request accepted this cycle (combinational)
//   f_rvalid / f_rdata   fetch data return; rdata holds its last value otherwise
//   l_req / l_addr       load request and doubleword address, held until l_gnt
//   l_gnt                load request accepted this cycle (combinational)
//   l_rvalid / l_rdata   load data return; rdata holds its last value otherwise
//   mem_en / mem_addr    registered memory read strobe and address
//   mem_rdata            memory data, valid LAT cycles after mem_en
// ---------------------------------------------------------------------------
module ppc_mem_read_arbiter #(
   parameter int LAT = 1,
   parameter int AW  = 61,
   parameter int DW  = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [DW-1:0] f_rdata,
   input  logic          l_req,
   input  logic [AW-1:0] l_addr,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic [DW-1:0] l_rdata,
   output logic          mem_en,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata
);

   logic          fGntS;
   logic          lGntS;
   logic          anyGntS;
   logic          prioR;       // 1: L wins on contention, 0: F wins
   logic [LAT:0]  tagValidR;   // stage 0 = read issued this cycle on mem_en
   logic [LAT:0]  tagOwnerR;   // 1: owner is L, 0: owner is F
   logic          headValidS;
   logic [DW-1:0] fDataR;
   logic [DW-1:0] lDataR;

   // Arbiter: grant at most one requester. Never grant while reset is high.
   always_comb begin
      fGntS = 1'b0;
      lGntS = 1'b0;
      if (reset) begin
         fGntS = 1'b0;
         lGntS = 1'b0;
      end else if (f_req && l_req) begin
         if (prioR) begin
            lGntS = 1'b1;
         end else begin
            fGntS = 1'b1;
         end
      end else begin
         fGntS = f_req;
         lGntS = l_req;
      end
   end

   assign anyGntS = fGntS | lGntS;
   assign f_gnt   = fGntS;
   assign l_gnt   = lGntS;

   // Priority pointer. It flips only on a contended grant in round-robin mode.
   // In fixed mode it stays pinned to L.
   always_ff @(posedge clk) begin
      if (reset) begin
         prioR <= 1'b1;
`ifdef MEM_ARB_RR_EN
      end else if (f_req && l_req) begin
         prioR <= ~prioR;
`endif
      end else begin
         prioR <= prioR;
      end
   end

   // Issue stage and tag pipeline. The tag pipeline shifts every cycle.
   // A cycle with no grant inserts a bubble tag.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_en    <= 1'b0;
         mem_addr  <= {AW{1'b0}};
         tagValidR <= {(LAT+1){1'b0}};
         tagOwnerR <= {(LAT+1){1'b0}};
      end else begin
         mem_en <= anyGntS;
         if (lGntS) begin
            mem_addr <= l_addr;
         end else if (fGntS) begin
            mem_addr <= f_addr;
         end else begin
            mem_addr <= mem_addr;
         end
         tagValidR <= {tagValidR[LAT-1:0], anyGntS};
         tagOwnerR <= {tagOwnerR[LAT-1:0], lGntS};
      end
   end

   // The head stage lines up with the cycle in which mem_rdata is valid.
   // Gating with reset discards data that returns while a flush is in progress.
   assign headValidS = tagValidR[LAT] & ~reset;
   assign f_rvalid   = headValidS & ~tagOwnerR[LAT];
   assign l_rvalid   = headValidS &  tagOwnerR[LAT];

   // Return-data holding registers. Each keeps the last doubleword delivered
   // to its side, so the non-owner's rdata stays stable.
   always_ff @(posedge clk) begin
      if (reset) begin
         fDataR <= {DW{1'b0}};
         lDataR <= {DW{1'b0}};
      end else begin
         if (f_rvalid) begin
            fDataR <= mem_rdata;
         end else begin
            fDataR <= fDataR;
         end
         if (l_rvalid) begin
            lDataR <= mem_rdata;
         end else begin
            lDataR <= lDataR;
         end
      end
   end

   assign f_rdata = f_rvalid ? mem_rdata : fDataR;
   assign l_rdata = l_rvalid ? mem_rdata : lDataR;

endmodule

// File: tb/tb_ppc_mem_read_arbiter.sv
// Directed self-checking bench for ppc_mem_read_arbiter.
// Instance 1 uses LAT=1 and instance 3 uses LAT=3. Each instance has a small
// pipelined memory model that returns memWord(addr) LAT cycles after mem_en.
module tb_ppc_mem_read_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // LAT=1 instance
   logic        rst1, fReq1, lReq1, fGnt1, lGnt1, fRv1, lRv1, memEn1;
   logic [60:0] fAddr1, lAddr1, memAddr1;
   logic [63:0] fData1, lData1, memRd1, md1;

   // LAT=3 instance
   logic        rst3, fReq3, lReq3, fGnt3, lGnt3, fRv3, lRv3, memEn3;
   logic [60:0] fAddr3, lAddr3, memAddr3;
   logic [63:0] fData3, lData3, memRd3, md3a, md3b, md3c;

   function automatic logic [63:0] memWord(input logic [60:0] a);
      logic [63:0] w;
      w = {3'b000, a};
      return w ^ 64'hC0DE_0000_0000_0000;
   endfunction

   ppc_mem_read_arbiter #(.LAT(1), .AW(61), .DW(64)) dut1 (
      .clk(clk), .reset(rst1),
      .f_req(fReq1), .f_addr(fAddr1), .f_gnt(fGnt1), .f_rvalid(fRv1), .f_rdata(fData1),
      .l_req(lReq1), .l_addr(lAddr1), .l_gnt(lGnt1), .l_rvalid(lRv1), .l_rdata(lData1),
      .mem_en(memEn1), .mem_addr(memAddr1), .mem_rdata(memRd1));

   ppc_mem_read_arbiter #(.LAT(3), .AW(61), .DW(64)) dut3 (
      .clk(clk), .reset(rst3),
      .f_req(fReq3), .f_addr(fAddr3), .f_gnt(fGnt3), .f_rvalid(fRv3), .f_rdata(fData3),
      .l_req(lReq3), .l_addr(lAddr3), .l_gnt(lGnt3), .l_rvalid(lRv3), .l_rdata(lData3),
      .mem_en(memEn3), .mem_addr(memAddr3), .mem_rdata(memRd3));

   // Memory models: data for a strobe in cycle C is visible in cycle C+LAT.
   always @(posedge clk) begin
      md1  <= memEn1 ? memWord(memAddr1) : 64'hDEAD_BEEF_DEAD_BEEF;
      md3a <= memEn3 ? memWord(memAddr3) : 64'hDEAD_BEEF_DEAD_BEEF;
      md3b <= md3a;
      md3c <= md3b;
   end
   assign memRd1 = md1;
   assign memRd3 = md3c;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst1 = 1'b1; rst3 = 1'b1;
      fReq1 = 1'b0; lReq1 = 1'b0; fAddr1 = 61'd0; lAddr1 = 61'd0;
      fReq3 = 1'b0; lReq3 = 1'b0; fAddr3 = 61'd0; lAddr3 = 61'd0;
      tick; tick;
      fReq1 = 1'b1; lReq3 = 1'b1; #1;
      checks++;
      if ({fGnt1, lGnt1, fGnt3, lGnt3} !== 4'b0000) begin
         failures++; $display("FAIL reset_gnt: got %b expected 0000", {fGnt1, lGnt1, fGnt3, lGnt3});
      end
      checks++;
      if ({memEn1, fRv1, lRv1, memEn3, fRv3, lRv3} !== 6'b000000) begin
         failures++; $display("FAIL reset_ctl: got %b expected 000000", {memEn1, fRv1, lRv1, memEn3, fRv3, lRv3});
      end
      checks++;
      if ({memAddr1, memAddr3} !== 122'd0) begin
         failures++; $display("FAIL reset_addr: got %h/%h expected 0/0", memAddr1, memAddr3);
      end
      checks++;
      if ({fData1, lData1, fData3, lData3} !== 256'd0) begin
         failures++; $display("FAIL reset_data: got %h %h %h %h expected all 0", fData1, lData1, fData3, lData3);
      end
      tick;
      fReq1 = 1'b0; lReq3 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;
      tick;
   endtask

   task automatic test_single;
      tick; fReq1 = 1'b1; fAddr1 = 61'd0; #1;
      checks++;
      if ({fGnt1, lGnt1} !== 2'b10) begin
         failures++; $display("FAIL single_gnt: got %b expected 10", {fGnt1, lGnt1});
      end
      tick; fReq1 = 1'b0; #1;
      checks++;
      if ({memEn1, memAddr1, fRv1} !== {1'b1, 61'd0, 1'b0}) begin
         failures++; $display("FAIL single_issue: en=%b addr=%h rv=%b expected en=1 addr=0 rv=0", memEn1, memAddr1, fRv1);
      end
      tick; #1;
      checks++;
      if ({fRv1, lRv1} !== 2'b10 || fData1 !== memWord(61'd0)) begin
         failures++; $display("FAIL single_ret: rv=%b data=%h expected rv=10 data=%h", {fRv1, lRv1}, fData1, memWord(61'd0));
      end
      tick; #1;
      checks++;
      if ({fRv1, lRv1} !== 2'b00 || fData1 !== memWord(61'd0)) begin
         failures++; $display("FAIL single_hold: rv=%b data=%h expected rv=00 data=%h", {fRv1, lRv1}, fData1, memWord(61'd0));
      end
   endtask

   task automatic test_priority;
      tick;
      fReq1 = 1'b1; fAddr1 = 61'h10; lReq1 = 1'b1; lAddr1 = 61'h20; #1;
      checks++;
      if ({fGnt1, lGnt1} !== 2'b01) begin
         failures++; $display("FAIL prio_first: got %b expected 01", {fGnt1, lGnt1});
      end
      tick; lReq1 = 1'b0; #1;
      checks++;
      if ({fGnt1, lGnt1, memEn1, memAddr1} !== {2'b10, 1'b1, 61'h20}) begin
         failures++; $display("FAIL prio_second: gnt=%b en=%b addr=%h expected gnt=10 en=1 addr=20", {fGnt1, lGnt1}, memEn1, memAddr1);
      end
      tick; fReq1 = 1'b0; #1;
      checks++;
      if ({memEn1, memAddr1, fRv1, lRv1} !== {1'b1, 61'h10, 2'b01} || lData1 !== memWord(61'h20)) begin
         failures++; $display("FAIL prio_lret: en=%b addr=%h rv=%b ldata=%h expected en=1 addr=10 rv=01 ldata=%h", memEn1, memAddr1, {fRv1, lRv1}, lData1, memWord(61'h20));
      end
      tick; #1;
      checks++;
      if ({memEn1, fRv1, lRv1} !== 3'b010 || fData1 !== memWord(61'h10) || lData1 !== memWord(61'h20)) begin
         failures++; $display("FAIL prio_fret: en=%b rv=%b fdata=%h ldata=%h expected en=0 rv=10", memEn1, {fRv1, lRv1}, fData1, lData1);
      end
      tick;
   endtask

   // Round-robin: prio is F here, so L is raised, loses, then drops.
   // Fixed priority: F is raised, loses to L, then drops.
   task automatic test_contended_cancel;
      logic        winF;
      logic [60:0] winAddr;
`ifdef MEM_ARB_RR_EN
      winF = 1'b1;
`else
      winF = 1'b0;
`endif
      winAddr = winF ? 61'h30 : 61'h40;
      tick;
      fReq1 = 1'b1; fAddr1 = 61'h30; lReq1 = 1'b1; lAddr1 = 61'h40; #1;
      checks++;
      if ({fGnt1, lGnt1} !== {winF, ~winF}) begin
         failures++; $display("FAIL cancel_gnt: got %b expected %b", {fGnt1, lGnt1}, {winF, ~winF});
      end
      tick; fReq1 = 1'b0; lReq1 = 1'b0; #1;
      checks++;
      if ({fGnt1, lGnt1, memEn1, memAddr1} !== {2'b00, 1'b1, winAddr}) begin
         failures++; $display("FAIL cancel_issue: gnt=%b en=%b addr=%h expected gnt=00 en=1 addr=%h", {fGnt1, lGnt1}, memEn1, memAddr1, winAddr);
      end
      tick; #1;
      checks++;
      if ({memEn1, fRv1, lRv1} !== {1'b0, winF, ~winF} || (winF ? fData1 : lData1) !== memWord(winAddr)) begin
         failures++; $display("FAIL cancel_ret: en=%b rv=%b expected en=0 rv=%b", memEn1, {fRv1, lRv1}, {winF, ~winF});
      end
      for (int c = 0; c < 2; c++) begin
         tick; #1;
         checks++;
         if ({memEn1, fRv1, lRv1} !== 3'b000) begin
            failures++; $display("FAIL cancel_stray: cycle %0d en/rv=%b expected 000", c, {memEn1, fRv1, lRv1});
         end
      end
   endtask

   task automatic test_round_robin;
      logic expL [4];
      logic exL;
`ifdef MEM_ARB_RR_EN
      expL = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      expL = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      for (int c = 0; c < 6; c++) begin
         tick;
         fReq1 = (c < 4); lReq1 = (c < 4); fAddr1 = 61'h50; lAddr1 = 61'h60; #1;
         if (c < 4) begin
            checks++;
            if ({fGnt1, lGnt1} !== {~expL[c], expL[c]}) begin
               failures++; $display("FAIL rr_gnt: cycle %0d got %b expected %b", c, {fGnt1, lGnt1}, {~expL[c], expL[c]});
            end
         end
         if (c >= 2) begin
            exL = expL[c-2];
            checks++;
            if ({fRv1, lRv1} !== {~exL, exL} || (exL ? lData1 : fData1) !== (exL ? memWord(61'h60) : memWord(61'h50))) begin
               failures++; $display("FAIL rr_ret: cycle %0d rv=%b expected %b", c, {fRv1, lRv1}, {~exL, exL});
            end
         end
      end
      tick; #1;
      checks++;
      if ({fRv1, lRv1, memEn1} !== 3'b000) begin
         failures++; $display("FAIL rr_drain: got %b expected 000", {fRv1, lRv1, memEn1});
      end
   endtask

   task automatic test_pipelined_lat3;
      logic expRv, expEn;
      for (int c = 0; c < 10; c++) begin
         tick;
         fReq3 = (c < 5); fAddr3 = 61'(c); #1;
         expEn = (c >= 1) && (c <= 5);
         expRv = (c >= 4) && (c <= 8);
         checks++;
         if ({fGnt3, lGnt3} !== {(c < 5), 1'b0}) begin
            failures++; $display("FAIL lat3_gnt: cycle %0d got %b", c, {fGnt3, lGnt3});
         end
         checks++;
         if (memEn3 !== expEn || (expEn && memAddr3 !== 61'(c - 1))) begin
            failures++; $display("FAIL lat3_issue: cycle %0d en=%b addr=%h expected en=%b", c, memEn3, memAddr3, expEn);
         end
         checks++;
         if ({fRv3, lRv3} !== {expRv, 1'b0} || (expRv && fData3 !== memWord(61'(c - 4)))) begin
            failures++; $display("FAIL lat3_ret: cycle %0d rv=%b data=%h expected rv=%b", c, {fRv3, lRv3}, fData3, {expRv, 1'b0});
         end
      end
      fReq3 = 1'b0;
   endtask

   task automatic test_reset_flush;
      tick; fReq3 = 1'b1; fAddr3 = 61'h7; #1;
      checks++;
      if ({fGnt3, lGnt3} !== 2'b10) begin
         failures++; $display("FAIL flush_g1: got %b expected 10", {fGnt3, lGnt3});
      end
      tick; fReq3 = 1'b0; lReq3 = 1'b1; lAddr3 = 61'h9; #1;
      checks++;
      if ({fGnt3, lGnt3} !== 2'b01) begin
         failures++; $display("FAIL flush_g2: got %b expected 01", {fGnt3, lGnt3});
      end
      tick; lReq3 = 1'b0; fReq3 = 1'b1; rst3 = 1'b1; #1;
      checks++;
      if ({fGnt3, lGnt3} !== 2'b00) begin
         failures++; $display("FAIL flush_gnt_in_reset: got %b expected 00", {fGnt3, lGnt3});
      end
      tick; rst3 = 1'b0; fReq3 = 1'b0; #1;
      checks++;
      if ({memEn3, memAddr3, fData3, lData3} !== {1'b0, 61'd0, 128'd0}) begin
         failures++; $display("FAIL flush_state: en=%b addr=%h fdata=%h ldata=%h expected all 0", memEn3, memAddr3, fData3, lData3);
      end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({fRv3, lRv3} !== 2'b00) begin
            failures++; $display("FAIL flush_rvalid: cycle %0d got %b expected 00", c, {fRv3, lRv3});
         end
         tick;
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_priority;
      test_contended_cancel;
      test_round_robin;
      test_pipelined_lat3;
      test_reset_flush;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
